if_redirect_resp: RTL

- Responder (ack side) of the four-phase req/ack protocol, living in the IF clock domain (clk_if).
- Accepts branch-redirect requests issued by the ID stage from another clock domain.
- Synchronizes req, captures the bundled redirect address, offers it to the fetch PC logic over a valid/ready port, and returns ack.
- Keeps a redirect count and a sticky protocol-error flag for debug.

---
 rtl/cpu_hs_pkg.sv | 14 +
 rtl/hs_sync.sv | 28 ++
 rtl/if_redirect_resp.sv | 115 +++++++++++
 3 files changed

// File: rtl/cpu_hs_pkg.sv
// Shared handshake definitions for the four-phase req/ack responder and
// initiator FSMs of the fetch/decode redirect path.
package cpu_hs_pkg;

  localparam int PC_W           = 8;
  localparam int HS_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER  = 2'd1,
    ACK_HI = 2'd2
  } hs_resp_state_t;

endpackage

// File: rtl/hs_sync.sv
// N-flop level synchronizer with asynchronous active-high reset to 0.
// N must be at least 2; only single-bit level signals may pass through it.
module hs_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  // Shift the asynchronous level one stage deeper each clock.
  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  // Chain flops; cleared on reset so a held request is re-seen afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/if_redirect_resp.sv
// IF-domain responder of the four-phase redirect handshake from ID.
// Synchronizes req, captures the bundled address once req is seen, offers
// it to fetch over valid/ready, and returns a registered ack. Keeps a
// wrapping redirect count and a sticky flag for req dropped before ack.
module if_redirect_resp
  import cpu_hs_pkg::*;
#(
  parameter int ADDR_W      = PC_W,
  parameter int SYNC_STAGES = HS_SYNC_STAGES,  // 2..4
  parameter int CNT_W       = 8
) (
  input  logic              clk_if,
  input  logic              reset,
  input  logic              req_in,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              ack_out,
  output logic              redir_valid,
  output logic [ADDR_W-1:0] redir_addr,
  input  logic              redir_ready,
  output logic [CNT_W-1:0]  redir_count,
  output logic              proto_err
);

  logic req_s;

  hs_sync #(.N(SYNC_STAGES)) u_req_sync (
    .clk (clk_if),
    .rst (reset),
    .d   (req_in),
    .q   (req_s)
  );

  hs_resp_state_t    state_q, state_d;
  logic              ack_q, ack_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;

  // Next state and next registered outputs of the handshake FSM.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        // addr_in is only looked at once req_s is high: bundled-data
        // guarantee says it has been stable since req_in rose.
        if (req_s) begin
          addr_d  = addr_in;
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (redir_ready) begin
          count_d = count_q + CNT_W'(1);
          valid_d = 1'b0;
          if (req_s) begin
            ack_d   = 1'b1;
            state_d = ACK_HI;
          end else begin
            // Transfer happened but req is already gone: no ack phase.
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (!req_s) begin
          err_d   = 1'b1;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      ACK_HI: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any offer or ack at once.
  always_ff @(posedge clk_if or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign ack_out     = ack_q;
  assign redir_valid = valid_q;
  assign redir_addr  = addr_q;
  assign redir_count = count_q;
  assign proto_err   = err_q;

endmodule
